// File: rtl/shifter_if.sv
// Operand/result bundle for the shifter: the master drives operands, the slave returns the registered result.
interface shifter_if #(
    parameter int WIDTH = 32
);
    localparam int AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic [WIDTH-1:0] value_in;
    logic [1:0]       shiftop;
    logic [AMT_W-1:0] shiftamt;
    logic [WIDTH-1:0] result;
    logic             out_valid;

    modport master (
        output in_valid, value_in, shiftop, shiftamt,
        input  result, out_valid
    );

    modport slave (
        input  in_valid, value_in, shiftop, shiftamt,
        output result, out_valid
    );
endinterface

// File: rtl/shifter.sv
// Single-cycle logarithmic barrel shifter (SRL/SRA/SLL, op 11 = pass-through or rotate).
// Define SHIFTER_ROTATE_EN to turn op 11 into rotate-right; otherwise op 11 passes value_in through.
module shifter #(
    parameter int WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    shifter_if.slave sh
);
    localparam int AMT_W = $clog2(WIDTH);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        return {<<{x}};
    endfunction

`ifdef SHIFTER_ROTATE_EN
    // One barrel stage of distance n; rotate wraps the bits shifted out back into the top.
    function automatic logic [WIDTH-1:0] shr_stage(input logic [WIDTH-1:0] x,
                                                   input logic en, input int n,
                                                   input logic fill, input logic rot);
        logic [WIDTH-1:0] y;
        y = (x >> n) | (~(ONES >> n) & {WIDTH{fill}});
        if (rot) y = (x >> n) | (x << (WIDTH - n));
        return en ? y : x;
    endfunction
`else
    // One barrel stage of distance n; vacated top bits take the fill value.
    function automatic logic [WIDTH-1:0] shr_stage(input logic [WIDTH-1:0] x,
                                                   input logic en, input int n,
                                                   input logic fill);
        logic [WIDTH-1:0] y;
        y = (x >> n) | (~(ONES >> n) & {WIDTH{fill}});
        return en ? y : x;
    endfunction
`endif

    logic             is_left;
    logic             fill_bit;
    logic [WIDTH-1:0] net;
    logic [AMT_W-1:0] amt_sh;
    logic [WIDTH-1:0] net_out;
    logic [WIDTH-1:0] result_d;
    logic             out_valid_d;
`ifdef SHIFTER_ROTATE_EN
    logic             rot_en;
`endif

    logic [WIDTH-1:0] result_q;
    logic             out_valid_q;

    // Left shifts reuse the right-shift network by reversing bits on the way in and out.
    always_comb begin
        is_left  = (sh.shiftop == OP_SLL);
        fill_bit = (sh.shiftop == OP_SRA) && sh.value_in[WIDTH-1];
`ifdef SHIFTER_ROTATE_EN
        rot_en   = (sh.shiftop == OP_ROR);
`endif
        net    = is_left ? bit_rev(sh.value_in) : sh.value_in;
        amt_sh = '0;
        for (int s = 0; s < AMT_W; s++) begin
            amt_sh = sh.shiftamt >> s;
`ifdef SHIFTER_ROTATE_EN
            net = shr_stage(net, amt_sh[0], 1 << s, fill_bit, rot_en);
`else
            net = shr_stage(net, amt_sh[0], 1 << s, fill_bit);
`endif
        end
        net_out = is_left ? bit_rev(net) : net;

`ifdef SHIFTER_ROTATE_EN
        result_d = net_out;
`else
        result_d = (sh.shiftop == OP_ROR) ? sh.value_in : net_out;
`endif
        out_valid_d = sh.in_valid;
    end

    // Result register: reset wins over in_valid; idle cycles hold the last result.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (sh.in_valid) result_q <= result_d;
        end
    end

    assign sh.result    = result_q;
    assign sh.out_valid = out_valid_q;
endmodule

// File: tb/tb_shifter.sv
// Directed + random bench for shifter with an expected-result queue checked one cycle after each issue.
module tb_shifter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    shifter_if #(.WIDTH(32)) bus ();

    shifter #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .sh    (bus)
    );

    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res    = 32'h0;

    function automatic logic [31:0] model(input logic [31:0] v, input logic [1:0] op,
                                          input logic [4:0] a);
        logic signed [31:0] sv;
        sv = v;
        case (op)
            2'b00: return v >> a;
            2'b01: return sv >>> a;
            2'b10: return v << a;
`ifdef SHIFTER_ROTATE_EN
            default: return (v >> a) | (v << (6'd32 - {1'b0, a}));
`else
            default: return v;
`endif
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then compare the registered outputs #1 after the edge.
    task automatic step(input logic rst_v, input logic v, input logic [31:0] val,
                        input logic [1:0] op, input logic [4:0] amt,
                        input logic [31:0] exp, input string tag);
        logic [31:0] want;
        reset        = rst_v;
        bus.in_valid = v;
        bus.value_in = val;
        bus.shiftop  = op;
        bus.shiftamt = amt;
        if (v && !rst_v) exp_q.push_back(exp);
        @(posedge clock);
        #1;
        check({tag, ".ov"}, {31'b0, bus.out_valid}, {31'b0, v && !rst_v});
        if (rst_v) begin
            last_res = 32'h0;
            check({tag, ".res"}, bus.result, last_res);
        end else if (v) begin
            if (exp_q.size() == 0) begin
                check({tag, ".queue"}, 32'h1, 32'h0);
            end else begin
                want     = exp_q.pop_front();
                last_res = want;
                check({tag, ".res"}, bus.result, want);
            end
        end else begin
            check({tag, ".hold"}, bus.result, last_res);
        end
    endtask

    task automatic stepm(input logic [31:0] val, input logic [1:0] op,
                         input logic [4:0] amt, input string tag);
        step(1'b0, 1'b1, val, op, amt, model(val, op, amt), tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rv;
        logic [1:0]  rop;
        logic [4:0]  ra;
        bus.in_valid = 1'b0;
        bus.value_in = '0;
        bus.shiftop  = '0;
        bus.shiftamt = '0;
        #1;

        // Reset with a simultaneous operation: discarded.
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 2'b10, 5'd6, 32'h0, "rst_pri");
        step(1'b1, 1'b0, 32'h0, 2'b00, 5'd0, 32'h0, "rst_idle");

        // First edge after reset accepts; SLL then SRL back-to-back.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 2'b10, 5'd6,  32'hFFFF_FFC0, "sll6");
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 2'b00, 5'd24, 32'h0000_00FF, "srl24");
        step(1'b0, 1'b1, 32'hAAAA_AAAA, 2'b01, 5'd6,  32'hFEAA_AAAA, "sra_neg");
        step(1'b0, 1'b1, 32'h5555_5555, 2'b01, 5'd6,  32'h0155_5555, "sra_pos");
`ifdef SHIFTER_ROTATE_EN
        step(1'b0, 1'b1, 32'h8000_0001, 2'b11, 5'd1,  32'hC000_0000, "op11");
        step(1'b0, 1'b1, 32'h1234_5678, 2'b11, 5'd31, 32'h2468_ACF0, "ror31");
`else
        step(1'b0, 1'b1, 32'h8000_0001, 2'b11, 5'd1,  32'h8000_0001, "op11");
        step(1'b0, 1'b1, 32'h1234_5678, 2'b11, 5'd31, 32'h1234_5678, "pass31");
`endif

        // Zero distance is identity for every op.
        for (int o = 0; o < 4; o++)
            step(1'b0, 1'b1, 32'h9234_5678, 2'(o), 5'd0, 32'h9234_5678, "amt0");

        // Maximum distance.
        step(1'b0, 1'b1, 32'h8000_0000, 2'b00, 5'd31, 32'h0000_0001, "srl31");
        step(1'b0, 1'b1, 32'h8000_0000, 2'b01, 5'd31, 32'hFFFF_FFFF, "sra31n");
        step(1'b0, 1'b1, 32'h7FFF_FFFF, 2'b01, 5'd31, 32'h0000_0000, "sra31p");
        step(1'b0, 1'b1, 32'h0000_0001, 2'b10, 5'd31, 32'h8000_0000, "sll31");

        // Hold while idle, then reset with in_valid high.
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 2'b10, 5'd4, 32'hEADB_EEF0, "pre_hold");
        step(1'b0, 1'b0, 32'h1111_1111, 2'b00, 5'd1, 32'h0, "hold1");
        step(1'b0, 1'b0, 32'h2222_2222, 2'b10, 5'd3, 32'h0, "hold2");
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 2'b00, 5'd0, 32'h0, "rst_mid");
        step(1'b0, 1'b1, 32'h0F0F_0F0F, 2'b10, 5'd8, 32'h0F0F_0F00, "post_rst");

        // Random operations, some idle gaps.
        for (int i = 0; i < 60; i++) begin
            rv  = $urandom;
            rop = 2'($urandom_range(0, 3));
            ra  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 4) == 0)
                step(1'b0, 1'b0, rv, rop, ra, 32'h0, "rnd_idle");
            else
                stepm(rv, rop, ra, "rnd");
        end

        step(1'b0, 1'b0, 32'h0, 2'b00, 5'd0, 32'h0, "drain");
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shifter.md
SHIFTER -- requirements
Module: shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; only 32 is required to be supported.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands valid this cycle; sampled on rising clock edge.
REQ-005 value_in  input  32  operand to be shifted.
REQ-006 shiftop  input  2  operation select: 00 SRL, 01 SRA, 10 SLL, 11 ROR/pass (see REQ-025).
REQ-007 shiftamt  input  5  shift distance 0..31, unsigned.
REQ-008 result  output  32  registered shift result.
REQ-009 out_valid  output  1  result holds the outcome of an accepted operation.

Function
REQ-010 The shifter SHALL, on a rising clock edge with in_valid=1 and reset=0, compute the selected operation on value_in/shiftamt and load it into result.
REQ-011 The shifter SHALL provide a latency of exactly one cycle: result is valid on the edge after in_valid is sampled, with out_valid=1 in that same cycle.
REQ-012 The shifter SHALL accept a new operation every cycle (throughput 1/cycle; no backpressure).
REQ-013 The shifter SHALL, on a rising edge with in_valid=0, hold result unchanged and drive out_valid=0.
REQ-014 SRL (00): result SHALL be value_in shifted right by shiftamt, zero-filled from bit 31.
REQ-015 SRA (01): result SHALL be value_in shifted right by shiftamt, filled with copies of value_in[31].
REQ-016 SLL (10): result SHALL be value_in shifted left by shiftamt, zero-filled from bit 0.
REQ-017 The shifter SHALL return value_in unchanged for shiftamt=0 for every op.
REQ-018 The shifter SHALL treat shiftamt=31 as a legal maximum (SRL leaves bit 0 = value_in[31], SRA gives all bits = value_in[31], SLL leaves bit 31 = value_in[0]).
REQ-019 The shift network SHALL be a 5-stage logarithmic barrel (1, 2, 4, 8, 16), with each stage controlled by one shiftamt bit.
REQ-020 Left shifts SHALL share the right-shift network through bit reversal of input and output.
REQ-021 The shift network SHALL be purely combinational between the input pins and the result register; there is no other internal state.

Reset
REQ-022 The shifter SHALL, on a rising edge with reset=1, set result=32'h00000000 and out_valid=0, regardless of in_valid.
REQ-023 The shifter SHALL let reset take priority over a simultaneous in_valid; an operation presented during reset is discarded and not output afterwards.
REQ-024 The shifter SHALL accept an operation on the first edge after reset deasserts.

Configuration
REQ-025 Macro SHIFTER_ROTATE_EN: when defined, shiftop=11 SHALL perform rotate right by shiftamt (bits leaving bit 0 re-enter at bit 31).
REQ-026 Without SHIFTER_ROTATE_EN, shiftop=11 SHALL load value_in unmodified into result (pass-through), and no rotate logic SHALL be present.

Verification
REQ-027 SLL: value_in=FFFFFFFF, shiftop=10, shiftamt=6, in_valid=1 -> next cycle result=FFFFFFC0, out_valid=1.
REQ-028 SRL: value_in=FFFFFFFF, shiftop=00, shiftamt=24 -> result=000000FF.
REQ-029 SRA negative: value_in=AAAAAAAA, shiftop=01, shiftamt=6 -> result=FEAAAAAA; SRA positive: value_in=55555555, same op/amt -> result=01555555.
REQ-030 Op 11: value_in=80000001, shiftamt=1 -> result=C0000000 with SHIFTER_ROTATE_EN, 80000001 without it.
REQ-031 Hold/reset: after a valid op, drive in_valid=0 -> result held, out_valid=0; assert reset together with in_valid=1 -> result=00000000, out_valid=0.
REQ-032 Back-to-back: issue SLL then SRL on consecutive cycles -> results appear on consecutive cycles, each with out_valid=1.
